// File: rtl/iddr_deser.sv
// iddr_deser: multi-lane DDR input deserializer.
// Collects rise/fall sample pairs per lane into RATIO-bit words on clk.
// The word window can be shifted one bit at a time with bitslip.
// Optional build macro IDDR_DESER_TRAIN_EN adds an automatic training FSM.
// The FSM slips the window until every lane shows TRAIN_PATTERN twice in a row.
// Without the macro, train_start is ignored and locked/train_fail stay low.

module iddr_deser #(
  parameter int               WIDTH         = 1,
  parameter int               RATIO         = 4,
  parameter                   FIRST_EDGE    = "RISE",
  parameter logic [RATIO-1:0] TRAIN_PATTERN = RATIO'(4'b1011)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       din_rise,
  input  logic [WIDTH-1:0]       din_fall,
  input  logic                   in_valid,
  input  logic                   bitslip,
  input  logic                   train_start,
  output logic [WIDTH*RATIO-1:0] word,
  output logic                   word_valid,
  output logic                   locked,
  output logic                   train_fail
);

  // History depth: two words, so any RATIO-bit window at offsets 0..RATIO-1 fits.
  localparam int HW = 2 * RATIO;
  localparam int BW = (RATIO / 2 > 1) ? $clog2(RATIO / 2) : 1;
  localparam int OW = $clog2(RATIO);

  localparam logic [BW-1:0] LP_LAST_BEAT  = BW'(RATIO / 2 - 1);
  localparam logic [OW-1:0] LP_LAST_OFS   = OW'(RATIO - 1);
  localparam bit            LP_RISE_FIRST = (FIRST_EDGE == "RISE");

  // Reject parameter combinations the datapath cannot represent.
  if (WIDTH < 1 || WIDTH > 16) begin : g_badWidth
    $error("iddr_deser: WIDTH must be 1..16");
  end
  if (RATIO < 2 || RATIO > 16 || (RATIO % 2) != 0) begin : g_badRatio
    $error("iddr_deser: RATIO must be even, 2..16");
  end

  logic [HW-1:0]          r_hist     [WIDTH];
  logic [HW-1:0]          w_histNext [WIDTH];
  logic [BW-1:0]          r_beatCnt;
  logic [OW-1:0]          r_ofs;
  logic [WIDTH*RATIO-1:0] r_word;
  logic                   r_wordValid;
  logic                   w_slip;
  logic [WIDTH-1:0]       w_unusedHistTop;

  // Per-lane next-history value: drop the two oldest bits, append older then newer sample.
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    logic w_older;
    logic w_newer;

    assign w_older       = LP_RISE_FIRST ? din_rise[k] : din_fall[k];
    assign w_newer       = LP_RISE_FIRST ? din_fall[k] : din_rise[k];
    assign w_histNext[k] = {r_hist[k][HW-3:0], w_older, w_newer};

    // The two top history bits shift out and never reach a word window.
    assign w_unusedHistTop[k] = ^r_hist[k][HW-1:HW-2];
  end

  // History shift registers; held while in_valid is low, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < WIDTH; k++) begin
        r_hist[k] <= '0;
      end
    end else if (in_valid) begin
      for (int k = 0; k < WIDTH; k++) begin
        r_hist[k] <= w_histNext[k];
      end
    end
  end

  // Beat counter and word capture: on the wrap beat every lane samples its window at r_ofs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beatCnt   <= '0;
      r_word      <= '0;
      r_wordValid <= 1'b0;
    end else begin
      r_wordValid <= 1'b0;
      if (in_valid) begin
        if (r_beatCnt == LP_LAST_BEAT) begin
          r_beatCnt   <= '0;
          r_wordValid <= 1'b1;
          for (int k = 0; k < WIDTH; k++) begin
            r_word[k*RATIO +: RATIO] <= w_histNext[k][r_ofs +: RATIO];
          end
        end else begin
          r_beatCnt <= r_beatCnt + 1'b1;
        end
      end
    end
  end

  // Window offset shared by all lanes; a slip applies from the next cycle on.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ofs <= '0;
    end else if (w_slip) begin
      r_ofs <= (r_ofs == LP_LAST_OFS) ? '0 : r_ofs + 1'b1;
    end
  end

  assign word       = r_word;
  assign word_valid = r_wordValid;

`ifdef IDDR_DESER_TRAIN_EN

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  localparam logic [OW:0] LP_SLIP_LAST = (OW + 1)'(RATIO - 1);

  state_t      r_state;
  logic [1:0]  r_matchCnt;
  logic [OW:0] r_slipCnt;
  logic        r_discardCnt;
  logic        r_locked;
  logic        r_trainFail;
  logic        w_training;
  logic        w_allMatch;
  logic        w_unused;

  // Training owns the offset while it searches; train_start never moves the offset.
  assign w_training = (r_state == ST_CHECK) || (r_state == ST_SLIP) || (r_state == ST_WAIT);
  assign w_slip     = !train_start && (w_training ? (r_state == ST_SLIP) : bitslip);
  assign w_unused   = ^w_unusedHistTop;

  // True when every lane of the current output word equals the training pattern.
  always_comb begin
    w_allMatch = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      if (r_word[k*RATIO +: RATIO] != TRAIN_PATTERN) begin
        w_allMatch = 1'b0;
      end
    end
  end

  // Training FSM: check words, slip on mismatch, let two stale words pass, lock after two matches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_matchCnt   <= '0;
      r_slipCnt    <= '0;
      r_discardCnt <= 1'b0;
      r_locked     <= 1'b0;
      r_trainFail  <= 1'b0;
    end else if (train_start) begin
      r_state      <= ST_CHECK;
      r_matchCnt   <= '0;
      r_slipCnt    <= '0;
      r_discardCnt <= 1'b0;
      r_locked     <= 1'b0;
      r_trainFail  <= 1'b0;
    end else begin
      case (r_state)
        ST_CHECK: begin
          if (r_wordValid) begin
            if (w_allMatch) begin
              if (r_matchCnt == 2'd1) begin
                r_matchCnt <= 2'd2;
                r_locked   <= 1'b1;
                r_state    <= ST_LOCKED;
              end else begin
                r_matchCnt <= r_matchCnt + 1'b1;
              end
            end else begin
              r_matchCnt <= '0;
              r_state    <= ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          r_slipCnt <= r_slipCnt + 1'b1;
          if (r_slipCnt == LP_SLIP_LAST) begin
            r_trainFail <= 1'b1;
            r_state     <= ST_FAIL;
          end else begin
            r_discardCnt <= 1'b0;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wordValid) begin
            r_discardCnt <= ~r_discardCnt;
            if (r_discardCnt) begin
              r_state <= ST_CHECK;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign locked     = r_locked;
  assign train_fail = r_trainFail;

`else

  logic w_unused;

  // No training hardware: bitslip always drives the offset and the status flags stay low.
  assign w_slip     = bitslip;
  assign w_unused   = ^{train_start, w_unusedHistTop};
  assign locked     = 1'b0;
  assign train_fail = 1'b0;

`endif

endmodule

// File: tb/tb_iddr_deser.sv
// tb_iddr_deser: directed bench for iddr_deser.
// Three instances share the control inputs: RATIO=4 with FIRST_EDGE "RISE" and "FALL",
// and a two-lane instance whose lane 1 always sees the complement of lane 0.

module tb_iddr_deser;

  logic       clk;
  logic       resetn;
  logic       dinRise;
  logic       dinFall;
  logic [1:0] dinRiseWide;
  logic [1:0] dinFallWide;
  logic       inValid;
  logic       bitslip;
  logic       trainStart;

  logic [3:0] wordRise;
  logic       validRise;
  logic       lockedRise;
  logic       failRise;
  logic [3:0] wordFall;
  logic       validFall;
  logic       lockedFall;
  logic       failFall;
  logic [7:0] wordWide;
  logic       validWide;
  logic       lockedWide;
  logic       failWide;

  int vecCnt  = 0;
  int missCnt = 0;

  iddr_deser #(.WIDTH(1), .RATIO(4), .FIRST_EDGE("RISE"), .TRAIN_PATTERN(4'b1011)) uRise (
    .clk(clk), .resetn(resetn), .din_rise(dinRise), .din_fall(dinFall),
    .in_valid(inValid), .bitslip(bitslip), .train_start(trainStart),
    .word(wordRise), .word_valid(validRise), .locked(lockedRise), .train_fail(failRise)
  );

  iddr_deser #(.WIDTH(1), .RATIO(4), .FIRST_EDGE("FALL"), .TRAIN_PATTERN(4'b1011)) uFall (
    .clk(clk), .resetn(resetn), .din_rise(dinRise), .din_fall(dinFall),
    .in_valid(inValid), .bitslip(bitslip), .train_start(trainStart),
    .word(wordFall), .word_valid(validFall), .locked(lockedFall), .train_fail(failFall)
  );

  iddr_deser #(.WIDTH(2), .RATIO(4), .FIRST_EDGE("RISE"), .TRAIN_PATTERN(4'b1011)) uWide (
    .clk(clk), .resetn(resetn), .din_rise(dinRiseWide), .din_fall(dinFallWide),
    .in_valid(inValid), .bitslip(bitslip), .train_start(trainStart),
    .word(wordWide), .word_valid(validWide), .locked(lockedWide), .train_fail(failWide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCnt++;
    if (observed !== expected) begin
      missCnt++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One valid beat; lane 1 of the wide instance gets the complement of lane 0.
  task automatic applyStimulus(input logic r, input logic f);
    dinRise     = r;
    dinFall     = f;
    dinRiseWide = {~r, r};
    dinFallWide = {~f, f};
    inValid     = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseSlip();
    bitslip = 1'b1;
    @(posedge clk);
    #1;
    bitslip = 1'b0;
  endtask

  task automatic pulseTrain();
    trainStart = 1'b1;
    @(posedge clk);
    #1;
    trainStart = 1'b0;
  endtask

  // Two beats forming 1011 on a rise-first lane.
  task automatic sendWord1011();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
  endtask

  // Two beats forming 1101 on a rise-first lane.
  task automatic sendWord1101();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    resetn      = 1'b0;
    dinRise     = 1'b0;
    dinFall     = 1'b0;
    dinRiseWide = 2'b00;
    dinFallWide = 2'b00;
    inValid     = 1'b0;
    bitslip     = 1'b0;
    trainStart  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_word", 32'(wordRise), 32'h0);
    checkOutput("rst_valid", 32'(validRise), 32'h0);
    checkOutput("rst_locked", 32'(lockedRise), 32'h0);
    checkOutput("rst_fail", 32'(failRise), 32'h0);
    checkOutput("rst_wide", 32'(wordWide), 32'h0);
    resetn = 1'b1;
    idleCycle();

    // Basic assembly and edge ordering.
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_valid_beat1", 32'(validRise), 32'h0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("basic_valid", 32'(validRise), 32'h1);
    checkOutput("basic_rise", 32'(wordRise), 32'b1011);
    checkOutput("basic_fall", 32'(wordFall), 32'b0111);
    checkOutput("basic_wide", 32'(wordWide), 32'b0100_1011);
    idleCycle();
    checkOutput("basic_valid_drop", 32'(validRise), 32'h0);
    checkOutput("basic_hold", 32'(wordRise), 32'b1011);

    // Gaps between beats: no strobe until the completing beat.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("gap_valid_low", 32'(validRise), 32'h0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("gap_valid", 32'(validRise), 32'h1);
    checkOutput("gap_rise", 32'(wordRise), 32'b0110);
    checkOutput("gap_fall", 32'(wordFall), 32'b1001);
    checkOutput("gap_wide", 32'(wordWide), 32'b1001_0110);

    // Reset in the middle of a word drops the partial beat.
    applyStimulus(1'b1, 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_word", 32'(wordRise), 32'h0);
    checkOutput("midrst_valid", 32'(validRise), 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("midrst_no_early_word", 32'(validRise), 32'h0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_valid_after", 32'(validRise), 32'h1);
    checkOutput("midrst_rise", 32'(wordRise), 32'b0010);
    checkOutput("midrst_fall", 32'(wordFall), 32'b0001);
    checkOutput("midrst_wide", 32'(wordWide), 32'b1101_0010);

    // Bitslip on a continuous 1011 stream.
    sendWord1011();
    sendWord1011();
    checkOutput("slip0_rise", 32'(wordRise), 32'b1011);
    pulseSlip();
    sendWord1011();
    checkOutput("slip1_rise", 32'(wordRise), 32'b1101);
    checkOutput("slip1_fall", 32'(wordFall), 32'b1011);
    checkOutput("slip1_wide", 32'(wordWide), 32'b0010_1101);
    pulseSlip();
    pulseSlip();
    sendWord1011();
    checkOutput("slip3_rise", 32'(wordRise), 32'b0111);
    applyStimulus(1'b1, 1'b0);
    bitslip = 1'b1;
    applyStimulus(1'b1, 1'b1);
    bitslip = 1'b0;
    checkOutput("slip_on_word_old_ofs", 32'(wordRise), 32'b0111);
    sendWord1011();
    checkOutput("slip_wrap_rise", 32'(wordRise), 32'b1011);

`ifdef IDDR_DESER_TRAIN_EN
    // Training on a 1101 stream needs three slips to find 1011.
    pulseTrain();
    for (int i = 0; i < 400 && !lockedRise; i++) begin
      applyStimulus((i % 2) == 0, 1'b1);
    end
    checkOutput("train_locked", 32'(lockedRise), 32'h1);
    checkOutput("train_word", 32'(wordRise), 32'b1011);
    checkOutput("train_no_fail", 32'(failRise), 32'h0);

    // Training on an all-zero stream exhausts every offset.
    pulseTrain();
    checkOutput("retrain_clears_lock", 32'(lockedRise), 32'h0);
    for (int i = 0; i < 400 && !failRise; i++) begin
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("train_fail", 32'(failRise), 32'h1);
    checkOutput("train_fail_unlocked", 32'(lockedRise), 32'h0);
    checkOutput("train_fail_word", 32'(wordRise), 32'h0);
`else
    // Without training hardware, train_start changes nothing.
    pulseTrain();
    sendWord1101();
    sendWord1101();
    checkOutput("notrain_locked", 32'(lockedRise), 32'h0);
    checkOutput("notrain_fail", 32'(failRise), 32'h0);
    checkOutput("notrain_word", 32'(wordRise), 32'b1101);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/iddr_deser.md
# iddr_deser

Parameterised multi-lane DDR input deserializer. It takes per-lane rising/falling-edge sample pairs, already captured by the DDR input registers on the pad side, and assembles them into RATIO-bit words on the system clock. It supports run-time bitslip alignment and an optional automatic training FSM. It sits between the pad-level DDR capture flops and the sensor/ADC front-end logic.

## Interface
- WIDTH, 1: number of lanes (1..16).
- RATIO, 4: bits per output word per lane; even, 2..16.
- FIRST_EDGE, "RISE": which sample of a pair is older, "RISE" or "FALL".
- TRAIN_PATTERN, 4'b1011: RATIO-bit expected word per lane during training.
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- din_rise  in  WIDTH  rising-edge sample per lane.
- din_fall  in  WIDTH  falling-edge sample per lane.
- in_valid  in  1  din_rise/din_fall carry a new sample pair this cycle.
- bitslip  in  1  one-cycle pulse; shift word window by one bit.
- train_start  in  1  one-cycle pulse; start auto-alignment (macro only).
- word  out  WIDTH*RATIO  lane k at word[k*RATIO +: RATIO], oldest bit at MSB.
- word_valid  out  1  one-cycle strobe, word is new.
- locked  out  1  training found alignment.
- train_fail  out  1  training exhausted all offsets.

## Operation
- Per lane, a 2*RATIO-bit history register hist. On in_valid it shifts left by 2: hist <= {hist[2R-3:0], older, newer}. older is din_rise when FIRST_EDGE="RISE", otherwise din_fall.
- beat_cnt counts 0..RATIO/2-1 on in_valid and wraps. On the wrap beat, word <= hist_next[ofs +: RATIO] for every lane and word_valid <= 1. hist_next is the value being written that cycle.
- ofs is 0..RATIO-1 and common to all lanes. A bitslip pulse does ofs <= (ofs+1) mod RATIO, taking effect on the following cycle.
- A bitslip in the same cycle as a word completion: the word uses the old ofs.
- Two bitslip pulses in consecutive cycles: both counted.
- in_valid low holds hist, beat_cnt and word. word_valid stays low.
- Reset values: hist=0, beat_cnt=0, ofs=0, word=0, word_valid=0, locked=0, train_fail=0, FSM=IDLE.
- Training FSM, IDLE/CHECK/SLIP/WAIT/LOCKED/FAIL:
  - IDLE -> CHECK on train_start.
  - CHECK, on each word_valid: if all lanes equal TRAIN_PATTERN, increment match_cnt. match_cnt=2 goes to LOCKED. A mismatch clears match_cnt and goes to SLIP.
  - SLIP: internal bitslip, increment slip_cnt. If slip_cnt reaches RATIO go to FAIL, else go to WAIT.
  - WAIT: discard 2 words, then go to CHECK.
  - LOCKED: locked=1. FAIL: train_fail=1.
  - train_start in any state clears locked, train_fail, match_cnt and slip_cnt, then enters CHECK without changing ofs.
  - An external bitslip while training is in progress is ignored.

## Timing
- Latency: word_valid is high the cycle after the in_valid beat where beat_cnt=RATIO/2-1. Throughput is one word per RATIO/2 valid beats.
- The first word after reset includes zero fill from hist when ofs>0.
- resetn assertion mid-word discards partial bits immediately. The first word after release needs RATIO/2 fresh beats.
- locked rises one cycle after the second matching word_valid.

## Configuration
- IDDR_DESER_TRAIN_EN defined: training FSM built, train_start honoured, locked/train_fail driven as above.
- Not defined: no FSM; train_start ignored; locked=0 and train_fail=0 constant; bitslip always honoured.

## Test plan
- WIDTH=1, RATIO=4, FIRST_EDGE="RISE": beats (rise,fall)=(1,0),(1,1) -> word=4'b1011, word_valid high one cycle after 2nd beat.
- Same stimulus with FIRST_EDGE="FALL" -> word=4'b0111.
- Continuous 1011 stream, one bitslip pulse -> following words=4'b1101. Four pulses total -> back to 4'b1011, one word later in the stream.
- in_valid gaps of 3 cycles between beats -> identical words, word_valid only on completing beats. resetn low after 1 beat -> outputs 0, next word needs 2 new beats.
- With IDDR_DESER_TRAIN_EN, stream 1101 repeating, train_start -> 3 internal slips, then locked=1 with word=4'b1011. Stream 0000 -> train_fail=1 after 4 slips.
- WIDTH=2: lane0 gets 1011 and lane1 gets 0100 on simultaneous beats -> word=8'b0100_1011.
